seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed driver for N common-anode seven-segment digits (active-low segments and digit enables). It accepts a packed nibble vector via a load strobe and scans one digit at a time. It supports BCD or hex decoding, leading-zero blanking and per-digit blinking. It sits between the timer datapath and the board display pins, replacing per-digit static decoders.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_encode.sv | 33 +++
 rtl/seg7_scan_driver.sv | 116 +++++++++++
 tb/tb_seg7_scan_driver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment patterns for the seven-segment scan driver.
// Patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble-to-segment encoder; BCD mode shows a dash for 10..15.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_hex_en,
  output logic [6:0] o_seg_n
);

  always_comb begin
    o_seg_n = SEG_DASH;
    case (i_nibble)
      4'h0: o_seg_n = SEG_0;
      4'h1: o_seg_n = SEG_1;
      4'h2: o_seg_n = SEG_2;
      4'h3: o_seg_n = SEG_3;
      4'h4: o_seg_n = SEG_4;
      4'h5: o_seg_n = SEG_5;
      4'h6: o_seg_n = SEG_6;
      4'h7: o_seg_n = SEG_7;
      4'h8: o_seg_n = SEG_8;
      4'h9: o_seg_n = SEG_9;
      4'hA: o_seg_n = i_hex_en ? SEG_A : SEG_DASH;
      4'hB: o_seg_n = i_hex_en ? SEG_B : SEG_DASH;
      4'hC: o_seg_n = i_hex_en ? SEG_C : SEG_DASH;
      4'hD: o_seg_n = i_hex_en ? SEG_D : SEG_DASH;
      4'hE: o_seg_n = i_hex_en ? SEG_E : SEG_DASH;
      4'hF: o_seg_n = i_hex_en ? SEG_F : SEG_DASH;
      default: o_seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with leading-zero
// blanking, per-digit blink and a dead cycle at the start of every slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  input  logic                    hex_en,
  input  logic                    blink_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   dig_n
);

  localparam int SCAN_W  = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int BLINK_W = (BLINK_DIV > 1)  ? $clog2(BLINK_DIV)  : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] r_value;
  logic                    r_blank_lz;
  logic [SCAN_W-1:0]       r_scan_cnt;
  logic [IDX_W-1:0]        r_dig_idx;
  logic [BLINK_W-1:0]      r_blink_cnt;
  logic                    r_blink_phase;
  logic [6:0]              r_seg_n;
  logic [NUM_DIGITS-1:0]   r_dig_n;

  logic                    w_scan_wrap;
  logic                    w_blink_wrap;
  logic [3:0]              w_nibble;
  logic [6:0]              w_dec_seg;
  logic [6:0]              w_seg_next;
  logic [NUM_DIGITS-1:0]   w_dig_next;
  logic [NUM_DIGITS-1:0]   w_lz_blank;
  logic                    w_zero_run;
  logic                    w_blink_blank;

  assign w_scan_wrap  = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign w_blink_wrap = (r_blink_cnt == BLINK_W'(BLINK_DIV - 1));
  assign w_nibble     = r_value[{r_dig_idx, 2'b00} +: 4];

  seg7_encode u_encode (
    .i_nibble (w_nibble),
    .i_hex_en (hex_en),
    .o_seg_n  (w_dec_seg)
  );

  // Walk from the most significant digit down; a digit is blankable while
  // everything at or above it is still zero. Digit 0 always stays lit.
  always_comb begin
    w_zero_run = 1'b1;
    w_lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run    = w_zero_run & (r_value[4*i +: 4] == 4'd0);
      w_lz_blank[i] = w_zero_run & (i != 0);
    end
  end

  assign w_blink_blank = blink_en & r_blink_phase & blink_mask[r_dig_idx];

  always_comb begin
    w_seg_next = w_dec_seg;
    if (w_blink_blank) begin
      w_seg_next = SEG_BLANK;
    end else if (r_blank_lz && w_lz_blank[r_dig_idx]) begin
      w_seg_next = SEG_BLANK;
    end
    w_dig_next = '1;
    if (r_scan_cnt != '0) begin
      w_dig_next = ~(NUM_DIGITS'(1) << r_dig_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value       <= '0;
      r_blank_lz    <= 1'b0;
      r_scan_cnt    <= '0;
      r_dig_idx     <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_seg_n       <= SEG_BLANK;
      r_dig_n       <= '1;
    end else begin
      if (load) begin
        r_value    <= value;
        r_blank_lz <= blank_lz;
      end
      if (w_scan_wrap) begin
        r_scan_cnt <= '0;
        r_dig_idx  <= (r_dig_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_dig_idx + 1'b1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      if (w_blink_wrap) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
      r_seg_n <= w_seg_next;
      r_dig_n <= w_dig_next;
    end
  end

  assign seg_n = r_seg_n;
  assign dig_n = r_dig_n;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 4-cycle slots, 16-cycle blink).
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic        hex_en;
  logic        blink_en;
  logic [3:0]  blink_mask;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .hex_en     (hex_en),
    .blink_en   (blink_en),
    .blink_mask (blink_mask),
    .seg_n      (seg_n),
    .dig_n      (dig_n)
  );

  typedef struct {
    string      tag;
    logic [6:0] seg;
    logic [3:0] dig;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference-side state: held value, held blank flag, cycles since reset.
  logic [15:0] m_val;
  logic        m_blz;
  int          m_k;

  function automatic logic [6:0] ref_dec(input logic [3:0] n, input logic hex);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = hex ? 7'b0001000 : 7'b0111111;
      4'hB: s = hex ? 7'b0000011 : 7'b0111111;
      4'hC: s = hex ? 7'b1000110 : 7'b0111111;
      4'hD: s = hex ? 7'b0100001 : 7'b0111111;
      4'hE: s = hex ? 7'b0000110 : 7'b0111111;
      default: s = hex ? 7'b0001110 : 7'b0111111;
    endcase
    return s;
  endfunction

  // One clock: work out what the pins must show after the coming edge,
  // let the edge happen, then hand the expectation to the monitor.
  task automatic step(input string tag);
    exp_t e;
    int   slot;
    int   cnt;
    int   ph;
    logic lz;
    e.tag = tag;
    if (!rst_n) begin
      e.seg = 7'b1111111;
      e.dig = 4'b1111;
    end else begin
      slot  = (m_k / SD) % ND;
      cnt   = m_k % SD;
      ph    = (m_k / BD) % 2;
      e.dig = (cnt == 0) ? 4'b1111 : ~(4'b0001 << slot);
      lz    = m_blz && (slot != 0);
      for (int j = slot; j < ND; j++) begin
        if (m_val[j*4 +: 4] != 4'd0) lz = 1'b0;
      end
      if (blink_en && ph == 1 && blink_mask[slot]) e.seg = 7'b1111111;
      else if (lz)                                  e.seg = 7'b1111111;
      else                                          e.seg = ref_dec(m_val[slot*4 +: 4], hex_en);
    end
    @(posedge clk);
    exp_q.push_back(e);
    if (!rst_n) begin
      m_val = '0;
      m_blz = 1'b0;
      m_k   = 0;
    end else begin
      if (load) begin
        m_val = value;
        m_blz = blank_lz;
      end
      m_k++;
    end
    #1;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_load(input logic [15:0] v, input logic blz, input string tag);
    load     = 1'b1;
    value    = v;
    blank_lz = blz;
    step(tag);
    load     = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (seg_n !== e.seg || dig_n !== e.dig) begin
          errors++;
          $display("FAIL %s t=%0t: got seg_n=%b dig_n=%b, want seg_n=%b dig_n=%b",
                   e.tag, $time, seg_n, dig_n, e.seg, e.dig);
        end
      end
    end
  end

  initial begin : stimulus
    int guard;
    rst_n      = 1'b0;
    load       = 1'b0;
    value      = '0;
    blank_lz   = 1'b0;
    hex_en     = 1'b0;
    blink_en   = 1'b0;
    blink_mask = '0;
    m_val      = '0;
    m_blz      = 1'b0;
    m_k        = 0;
    #1;

    run("reset", 3);
    rst_n = 1'b1;
    run("zeros", 20);

    do_load(16'h1234, 1'b0, "load_1234");
    run("bcd_1234", 20);

    do_load(16'h00A5, 1'b0, "load_00a5");
    run("bcd_dash", 16);
    hex_en = 1'b1;
    run("hex_a5", 16);

    do_load(16'hFEDC, 1'b0, "load_fedc");
    run("hex_fedc", 16);
    hex_en = 1'b0;
    run("bcd_fedc", 16);

    do_load(16'h0007, 1'b1, "load_0007");
    run("lz_0007", 16);
    do_load(16'h0000, 1'b1, "load_0000");
    run("lz_0000", 16);
    do_load(16'h0A00, 1'b1, "load_0a00");
    run("lz_0a00", 16);

    do_load(16'h5678, 1'b0, "load_5678");
    blink_en   = 1'b1;
    blink_mask = 4'b0001;
    run("blink_d0", 64);
    blink_mask = 4'b1010;
    run("blink_d13", 32);
    blink_en   = 1'b0;
    run("blink_off", 32);

    do_load(16'h9012, 1'b0, "load_9012");
    guard = 0;
    while (!(((m_k / SD) % ND == 2) && (m_k % SD == 2)) && guard < 64) begin
      step("seek_d2");
      guard++;
    end
    rst_n = 1'b0;
    load  = 1'b1;
    value = 16'h9999;
    step("rst_with_load");
    rst_n = 1'b1;
    load  = 1'b0;
    run("after_rst", 20);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
